// File: rtl/rcs16_serial.sv
// Digit-serial borrow-ripple subtractor: Diff = A - B - Bin, DIGIT bits per cycle.
// Operands are latched at start; results are registered and held until the next completion.
module rcs16_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             V,
    output logic             Z
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("rcs16_serial: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             v_q, v_d;
    logic             z_q, z_d;

    logic [DIGIT-1:0] da, db, dd;
    logic             br_c;

    always_comb begin : digit_sub
        logic brw;
        da  = a_q[cnt_q*DIGIT +: DIGIT];
        db  = b_q[cnt_q*DIGIT +: DIGIT];
        dd  = '0;
        brw = br_q;
        for (int i = 0; i < DIGIT; i++) begin
            dd[i] = da[i] ^ db[i] ^ brw;
            brw   = (~da[i] & db[i]) | (~(da[i] ^ db[i]) & brw);
        end
        br_c = brw;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        v_d     = v_q;
        z_d     = z_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = Bin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d[cnt_q*DIGIT +: DIGIT] = dd;
                br_d  = br_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // acc_d already holds the full difference on this edge
                    state_d = S_DONE;
                    diff_d  = acc_d;
                    bout_d  = br_c;
                    v_d     = (a_q[WIDTH-1] ^ b_q[WIDTH-1])
                            & (a_q[WIDTH-1] ^ acc_d[WIDTH-1]);
                    z_d     = (acc_d == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            v_q     <= v_d;
            z_q     <= z_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign Diff = diff_q;
    assign Bout = bout_q;
    assign V    = v_q;
    assign Z    = z_q;

endmodule

// File: doc/rcs16_serial.md
Name: rcs16_serial

Overview:
- Digit-serial borrow-ripple subtractor. Computes Diff = A - B - Bin over WIDTH/DIGIT clock cycles, DIGIT bits per cycle.
- Companion to the 16-bit ripple-carry adder in the arithmetic datapath library. Used where area matters more than latency.
- Start/done handshake. Operands are latched at start. Outputs are registered and held stable between operations.

Parameters:
- WIDTH, 16, operand and result width. Must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle. The borrow chain length per cycle is DIGIT.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only on an edge where busy=0.
- A  input  WIDTH  minuend; sampled on the accepting edge only.
- B  input  WIDTH  subtrahend; sampled on the accepting edge only.
- Bin  input  1  borrow-in; sampled on the accepting edge only.
- busy  output  1  high while an operation is in progress (state RUN).
- done  output  1  one-cycle pulse: result outputs updated this cycle.
- Diff  output  WIDTH  A - B - Bin, modulo 2^WIDTH.
- Bout  output  1  borrow-out; 1 iff A < B + Bin as unsigned numbers.
- V  output  1  signed overflow: (A[MSB]^B[MSB]) & (A[MSB]^Diff[MSB]).
- Z  output  1  1 iff Diff == 0.

Behaviour:
- Reset: state=IDLE; busy, done, Diff, Bout, V and Z are all 0; internal operand and accumulator registers are cleared.
- Reset wins over every other event on the same edge, including mid-RUN. A partial result is discarded and the outputs are not updated from it.
- States:
  - IDLE: start=1 latches A, B and Bin; sets count=0 and borrow=Bin; goes to RUN. busy rises in the next cycle.
  - RUN: each edge processes digit[count], bits count*DIGIT .. count*DIGIT+DIGIT-1.
    - Per-bit ripple: d = a ^ b ^ br; br_next = (~a & b) | (~(a ^ b) & br).
    - The digit result is written into the accumulator and borrow is updated.
    - On the edge processing the last digit (count = WIDTH/DIGIT - 1), go to DONE and load Diff, Bout, V and Z from the completed result.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start=1 in DONE is accepted exactly as in IDLE (back-to-back operation): the next state is RUN and done still deasserts.
- start while busy=1 is ignored. It causes no queuing and no corruption of the in-flight operation.
- Latency: start accepted at edge k; done=1 in the cycle after edge k+WIDTH/DIGIT. With the defaults, 4 RUN cycles, so done appears 5 cycles after start is sampled.
- Throughput: one result every WIDTH/DIGIT+1 cycles with back-to-back starts.
- Result outputs change only on the completion edge and hold until the next completion or reset. A, B and Bin may change freely after acceptance.
- Arithmetic is unsigned modulo 2^WIDTH. Bout is the final borrow; V uses the latched operands and is meaningful for two's-complement interpretation.
- Boundary: count wraps from WIDTH/DIGIT-1 to 0 only via a new start. With DIGIT=WIDTH, a single RUN cycle is required.
- Elaboration: if WIDTH is not a multiple of DIGIT, elaboration fails with an error.

Test Plan:
- Basic subtraction: A=0x0005, B=0x0003, Bin=0 -> Diff=0x0002, Bout=0, V=0, Z=0. done pulses exactly 5 cycles after start is sampled. busy is high for 4 cycles.
- Unsigned wrap: A=0x0000, B=0x0001, Bin=0 -> Diff=0xFFFF, Bout=1, V=0, Z=0. Then A=0x1234, B=0x1233, Bin=1 -> Diff=0x0000, Bout=0, Z=1.
- Signed overflow, positive: A=0x8000, B=0x0001 -> Diff=0x7FFF, V=1, Bout=0.
- Signed overflow, negative: A=0x7FFF, B=0xFFFF -> Diff=0x8000, V=1, Bout=1.
- Handshake:
  - Start 0x00FF-0x000F; pulse start with A=0xFFFF, B=0 in the 2nd RUN cycle -> it is ignored and the result is 0x00F0.
  - Assert start with A=0x0010, B=0x0001 during the DONE cycle -> accepted; 0x000F is reported 5 cycles later.
  - Outputs hold 0x00F0 until then.
- Reset mid-operation: assert reset in the 3rd RUN cycle -> next cycle busy=0, done=0, Diff=0, Bout=V=Z=0. A fresh start then completes normally (0x0100-0x0001 -> 0x00FF).
- Random regression: 10k random A/B/Bin with random start gaps, plus one parameter sweep at DIGIT=1, 2, 8 and 16. Compare each result against a reference model of A-B-Bin and the borrow/overflow formulas at every done pulse.
